// File: rtl/na_conf_wb_slave.sv
// Wishbone B3 slave front-end for the network adapter configuration block: registers each
// request, drives the simple reg_* interface and returns a registered ack/err.
module na_conf_wb_slave #(
  parameter int unsigned ADDR_LSB = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [15:0] reg_adr,
  output logic        reg_we,
  output logic [31:0] reg_data_o,
  input  logic [31:0] reg_data_i,
  input  logic        reg_ack,
  input  logic        reg_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StBurst} state_e;

  localparam logic [2:0] CtiIncr = 3'b010;
  localparam logic [2:0] CtiEnd  = 3'b111;

  state_e      state_q;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [2:0]  cti_q;
  logic [1:0]  bte_q;
  logic        ack_q;
  logic        err_q;

  logic [31:0] wrap_mask;
  logic [31:0] adr_next;
  logic        req;

  // The configuration block acks every access it does not err, so its ack carries no
  // extra information here.
  logic unused_reg_ack;
  assign unused_reg_ack = reg_ack;

  assign req = wb_cyc_i & wb_stb_i;

  // Only the bits inside the wrap window advance; everything above is held.
  always_comb begin
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = 32'h0000_000f;
      2'b10:   wrap_mask = 32'h0000_001f;
      2'b11:   wrap_mask = 32'h0000_003f;
      default: wrap_mask = '1;
    endcase
    adr_next = (adr_q & ~wrap_mask) | ((adr_q + 32'd4) & wrap_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cti_q   <= '0;
      bte_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            adr_q   <= wb_adr_i;
            wdat_q  <= wb_dat_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            cti_q   <= wb_cti_i;
            bte_q   <= wb_bte_i;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (!wb_cyc_i) begin
            state_q <= StIdle;
          end else begin
            rdat_q <= reg_data_i;
            // Partial writes are refused rather than performed as a full-word write.
            if (reg_err || (we_q && (sel_q != 4'hf))) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              ack_q <= 1'b1;
              if (!we_q && (cti_q == CtiIncr)) begin
                adr_q   <= adr_next;
                state_q <= StBurst;
              end else begin
                state_q <= StResp;
              end
            end
          end
        end
        StResp: begin
          if (!wb_cyc_i || wb_stb_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        StBurst: begin
          // ack_q always holds a prefetched beat here; a stb-low cycle keeps it pending.
          if (!wb_cyc_i) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end else if (wb_stb_i) begin
            if (wb_cti_i == CtiEnd) begin
              ack_q   <= 1'b0;
              state_q <= StIdle;
            end else if (reg_err) begin
              ack_q   <= 1'b0;
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              rdat_q <= reg_data_i;
              adr_q  <= adr_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reg_adr    = adr_q[ADDR_LSB+15:ADDR_LSB];
  assign reg_data_o = wdat_q;
  assign reg_we     = (state_q == StAccess) && we_q && (sel_q == 4'hf) && wb_cyc_i;

  // A response is only presented while the master is strobing for it.
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & req;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_na_conf_wb_slave.sv
// Directed bench for na_conf_wb_slave: expected responses and writes are queued by the
// master tasks and checked by an independent monitor.
module tb_na_conf_wb_slave;

  logic        clk;
  logic        rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [15:0] reg_adr;
  logic        reg_we;
  logic [31:0] reg_data_o;
  logic [31:0] reg_data_i;
  logic        reg_ack;
  logic        reg_err;

  typedef struct packed {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } rsp_t;

  typedef struct packed {
    logic [15:0] adr;
    logic [31:0] dat;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [31:0] w4_adr[4] = '{32'h0000_0008, 32'h0000_000c, 32'h0000_0000, 32'h0000_0004};
  logic [15:0] w4_nxt[4] = '{16'h000c, 16'h0000, 16'h0004, 16'h0008};
  logic [31:0] w4_dat[4] = '{32'hc0de_0008, 32'hc0de_000c, 32'h0000_0005, 32'hc0de_0004};

  na_conf_wb_slave #(.ADDR_LSB(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cti_i   (wb_cti_i),
    .wb_bte_i   (wb_bte_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_rty_o   (wb_rty_o),
    .reg_adr    (reg_adr),
    .reg_we     (reg_we),
    .reg_data_o (reg_data_o),
    .reg_data_i (reg_data_i),
    .reg_ack    (reg_ack),
    .reg_err    (reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration block stand-in: address 0 reads 5, 0x1000 errors, others echo the address.
  always_comb begin
    reg_err    = (reg_adr == 16'h1000);
    reg_ack    = ~reg_err;
    reg_data_i = (reg_adr == 16'h0000) ? 32'h0000_0005 : {16'hc0de, reg_adr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT responds or writes.
  initial begin
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) begin
        n_vec++;
        if (wb_ack_o && wb_err_o) begin
          n_miss++;
          $display("FAIL rsp_both: ack and err together");
        end else if (rsp_q.size() == 0) begin
          n_miss++;
          $display("FAIL rsp_unexpected: ack=%0b err=%0b dat=%h", wb_ack_o, wb_err_o, wb_dat_o);
        end else begin
          r = rsp_q.pop_front();
          if (r.err !== wb_err_o || (r.chk_dat && wb_dat_o !== r.dat)) begin
            n_miss++;
            $display("FAIL rsp: got err=%0b dat=%h, want err=%0b dat=%h", wb_err_o, wb_dat_o,
                     r.err, r.dat);
          end
        end
      end
      if (reg_we) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_miss++;
          $display("FAIL reg_we_unexpected: adr=%h dat=%h", reg_adr, reg_data_o);
        end else begin
          w = wr_q.pop_front();
          if (reg_adr !== w.adr || reg_data_o !== w.dat) begin
            n_miss++;
            $display("FAIL reg_write: got adr=%h dat=%h, want adr=%h dat=%h", reg_adr,
                     reg_data_o, w.adr, w.dat);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_cti_i = 3'b000;
    wb_bte_i = 2'b00;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic single(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic exp_err, input logic exp_we,
                        input logic [31:0] exp_rdat);
    int   lat = 0;
    rsp_t r;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cti_i = 3'b000;
    wb_bte_i = 2'b00;
    r.err     = exp_err;
    r.chk_dat = !we && !exp_err;
    r.dat     = exp_rdat;
    rsp_q.push_back(r);
    if (exp_we) wr_q.push_back({adr[15:0], dat});
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk("single_reg_adr", {16'h0, reg_adr}, {16'h0, adr[15:0]});
    end while (!(wb_ack_o || wb_err_o) && lat < 20);
    chk("single_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
  endtask

  // One read burst beat; nxt is the address the slave should already be fetching.
  task automatic beat(input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte,
                      input logic [31:0] exp_dat, input logic [15:0] nxt, input int exp_lat);
    int   lat = 0;
    rsp_t r;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = adr;
    wb_sel_i = 4'hf;
    wb_cti_i = cti;
    wb_bte_i = bte;
    r.err     = 1'b0;
    r.chk_dat = 1'b1;
    r.dat     = exp_dat;
    rsp_q.push_back(r);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2 && exp_lat == 3) chk("burst_first_adr", {16'h0, reg_adr}, adr);
    end while (!(wb_ack_o || wb_err_o) && lat < 20);
    chk("beat_latency", 32'(lat), 32'(exp_lat));
    chk("beat_next_adr", {16'h0, reg_adr}, {16'h0, nxt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    idle(3);
    @(negedge clk);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_err", 32'(wb_err_o), 32'd0);
    chk("rst_rty", 32'(wb_rty_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_reg_adr", {16'h0, reg_adr}, 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_data_o", reg_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Singles: read, full write, back-to-back read, partial write, erroring read.
    single(32'h0000_0000, 1'b0, 32'h0, 4'hf, 1'b0, 1'b0, 32'h0000_0005);
    single(32'h0000_0108, 1'b1, 32'h3, 4'hf, 1'b0, 1'b1, 32'h0);
    single(32'h0000_0108, 1'b0, 32'h0, 4'hf, 1'b0, 1'b0, 32'hc0de_0108);
    single(32'h0000_0108, 1'b1, 32'h3, 4'h3, 1'b1, 1'b0, 32'h0);
    single(32'h0000_1000, 1'b0, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
    idle(2);

    // Wrap4 burst from 0x8.
    for (int i = 0; i < 4; i++)
      beat(w4_adr[i], (i == 3) ? 3'b111 : 3'b010, 2'b01, w4_dat[i], w4_nxt[i],
           (i == 0) ? 3 : 1);
    idle(2);

    // Linear 8-beat burst from 0x200 with a two-cycle strobe gap.
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        wb_stb_i = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("gap_ack", 32'(wb_ack_o), 32'd0);
          chk("gap_reg_adr", {16'h0, reg_adr}, 32'h0000_020c);
          @(posedge clk);
          #1;
        end
      end
      beat(32'h200 + 32'(4 * i), (i == 7) ? 3'b111 : 3'b010, 2'b00,
           32'hc0de_0200 + 32'(4 * i), 16'h0204 + 16'(4 * i), (i == 0) ? 3 : 1);
    end
    idle(2);

    // cyc dropped after two beats: no further response, then a clean single.
    beat(32'h40, 3'b010, 2'b00, 32'hc0de_0040, 16'h0044, 3);
    beat(32'h44, 3'b010, 2'b00, 32'hc0de_0044, 16'h0048, 1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("cyc_drop_ack", 32'(wb_ack_o), 32'd0);
      @(posedge clk);
      #1;
    end
    single(32'h0000_0000, 1'b0, 32'h0, 4'hf, 1'b0, 1'b0, 32'h0000_0005);
    idle(2);

    // Reset during beat 2 of a linear burst; master keeps strobing through it.
    beat(32'h100, 3'b010, 2'b00, 32'hc0de_0100, 16'h0104, 3);
    beat(32'h104, 3'b010, 2'b00, 32'hc0de_0104, 16'h0108, 1);
    begin
      rsp_t r;
      r.err     = 1'b0;
      r.chk_dat = 1'b1;
      r.dat     = 32'hc0de_0108;
      rsp_q.push_back(r);
    end
    wb_adr_i = 32'h108;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    wb_adr_i = 32'h10c;
    @(negedge clk);
    chk("mid_rst_ack", 32'(wb_ack_o), 32'd0);
    chk("mid_rst_err", 32'(wb_err_o), 32'd0);
    chk("mid_rst_dat", wb_dat_o, 32'd0);
    chk("mid_rst_reg_adr", {16'h0, reg_adr}, 32'd0);
    chk("mid_rst_reg_we", 32'(reg_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    single(32'h0000_0000, 1'b0, 32'h0, 4'hf, 1'b0, 1'b0, 32'h0000_0005);
    idle(3);

    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
